lbdr_pkt_router: RTL and testbench

LBDR_PKT_ROUTER -- requirements
Module: lbdr_pkt_router

---
 rtl/lbdr_pkt_router.sv | 182 ++++++++++++++++++
 tb/tb_lbdr_pkt_router.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lbdr_pkt_router.sv
// -----------------------------------------------------------------------------
// lbdr_pkt_router
// Logic-based distributed routing (LBDR) output-port selector for one mesh
// router input. A header flit at the head of the input FIFO is routed using
// the local routing bits (Rxy), the connectivity bits (Cx) and this router's
// own address. The selected port is then locked for the rest of the packet,
// until a consumed tail flit releases it.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous, active-low reset
//   empty                 input FIFO empty (head flit valid when 0)
//   flit_id               type code of the head flit
//   dst_addr              destination {y,x} of the head flit (headers only)
//   rd                    downstream consumes the head flit this cycle
//   cfg_we                configuration write strobe (accepted only when idle)
//   cfg_rxy/cfg_cx/cfg_cur new routing bits, connectivity bits, own address
//   Nport..Lport          registered output-port select, at most one high
//   busy                  a packet route is locked
//   route_err             header with no legal output port
//   proto_err             flit type unexpected for the current state
//   cfg_err               configuration write attempted while locked
//   pkt_cnt               number of headers routed successfully (wraps)
// -----------------------------------------------------------------------------
module lbdr_pkt_router #(
   parameter int                     AXIS_W    = 2,
   parameter int                     FLIT_ID_W = 3,
   parameter logic [FLIT_ID_W-1:0]   HDR_ID    = 3'b001,
   parameter logic [FLIT_ID_W-1:0]   TAIL_ID   = 3'b100,
   parameter int                     CNT_W     = 16,
   parameter logic [7:0]             RXY_RST   = 8'h3C,
   parameter logic [3:0]             CX_RST    = 4'hF,
   parameter logic [2*AXIS_W-1:0]    CUR_RST   = 4'b0101
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   empty,
   input  logic [FLIT_ID_W-1:0]   flit_id,
   input  logic [2*AXIS_W-1:0]    dst_addr,
   input  logic                   rd,
   input  logic                   cfg_we,
   input  logic [7:0]             cfg_rxy,
   input  logic [3:0]             cfg_cx,
   input  logic [2*AXIS_W-1:0]    cfg_cur,
   output logic                   Nport,
   output logic                   Eport,
   output logic                   Wport,
   output logic                   Sport,
   output logic                   Lport,
   output logic                   busy,
   output logic                   route_err,
   output logic                   proto_err,
   output logic                   cfg_err,
   output logic [CNT_W-1:0]       pkt_cnt
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t                state_reg, state_next;
   logic [4:0]            port_reg, port_next;       // {L,S,W,E,N}
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [7:0]            rxy_reg, rxy_next;
   logic [3:0]            cx_reg, cx_next;
   logic [2*AXIS_W-1:0]   cur_reg, cur_next;
   logic                  route_err_reg, route_err_next;
   logic                  proto_err_reg, proto_err_next;
   logic                  cfg_err_reg, cfg_err_next;

   logic [AXIS_W-1:0]     y_dst, x_dst, y_cur, x_cur;
   logic                  n1, s1, e1, w1;
   logic [4:0]            route_raw, route_sel;

   assign y_dst = dst_addr[2*AXIS_W-1:AXIS_W];
   assign x_dst = dst_addr[AXIS_W-1:0];
   assign y_cur = cur_reg[2*AXIS_W-1:AXIS_W];
   assign x_cur = cur_reg[AXIS_W-1:0];

   assign n1 = (y_dst < y_cur);
   assign s1 = (y_cur < y_dst);
   assign e1 = (x_cur < x_dst);
   assign w1 = (x_dst < x_cur);

   // LBDR equations; a diagonal destination needs the matching turn bit.
   assign route_raw[0] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_reg[0]) | (n1 & w1 & rxy_reg[1])) & cx_reg[0];
   assign route_raw[1] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_reg[2]) | (e1 & s1 & rxy_reg[3])) & cx_reg[1];
   assign route_raw[2] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_reg[4]) | (w1 & s1 & rxy_reg[5])) & cx_reg[2];
   assign route_raw[3] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_reg[6]) | (s1 & w1 & rxy_reg[7])) & cx_reg[3];
   assign route_raw[4] = ~n1 & ~e1 & ~w1 & ~s1;

   // Permissive Rxy settings can enable two ports for a diagonal target;
   // keep only the lowest set bit (priority N, E, W, S, L) so the select
   // outputs stay one-hot.
   assign route_sel = route_raw & (~route_raw + 5'd1);

   always_comb begin
      state_next     = state_reg;
      port_next      = port_reg;
      cnt_next       = cnt_reg;
      rxy_next       = rxy_reg;
      cx_next        = cx_reg;
      cur_next       = cur_reg;
      route_err_next = 1'b0;
      proto_err_next = 1'b0;
      cfg_err_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               if (flit_id == HDR_ID) begin
                  if (|route_sel) begin
                     port_next  = route_sel;
                     state_next = LOCK;
                     cnt_next   = cnt_reg + CNT_W'(1);
                  end else begin
                     route_err_next = 1'b1;
                  end
               end else begin
                  proto_err_next = 1'b1;
               end
            end
            // Route above already used the old configuration values.
            if (cfg_we) begin
               rxy_next = cfg_rxy;
               cx_next  = cfg_cx;
               cur_next = cfg_cur;
            end
         end
         LOCK: begin
            if (!empty) begin
               if ((flit_id == TAIL_ID) && rd) begin
                  port_next  = 5'b0;
                  state_next = IDLE;
               end else if (flit_id == HDR_ID) begin
                  proto_err_next = 1'b1;
               end
            end
            if (cfg_we) begin
               cfg_err_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            port_next  = 5'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         port_reg      <= 5'b0;
         cnt_reg       <= '0;
         rxy_reg       <= RXY_RST;
         cx_reg        <= CX_RST;
         cur_reg       <= CUR_RST;
         route_err_reg <= 1'b0;
         proto_err_reg <= 1'b0;
         cfg_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         port_reg      <= port_next;
         cnt_reg       <= cnt_next;
         rxy_reg       <= rxy_next;
         cx_reg        <= cx_next;
         cur_reg       <= cur_next;
         route_err_reg <= route_err_next;
         proto_err_reg <= proto_err_next;
         cfg_err_reg   <= cfg_err_next;
      end
   end

   assign Nport     = port_reg[0];
   assign Eport     = port_reg[1];
   assign Wport     = port_reg[2];
   assign Sport     = port_reg[3];
   assign Lport     = port_reg[4];
   assign busy      = (state_reg == LOCK);
   assign route_err = route_err_reg;
   assign proto_err = proto_err_reg;
   assign cfg_err   = cfg_err_reg;
   assign pkt_cnt   = cnt_reg;

endmodule

// File: tb/tb_lbdr_pkt_router.sv
// -----------------------------------------------------------------------------
// tb_lbdr_pkt_router
// Directed vector table, randomized run against a behavioural model, and
// hand-written asynchronous-reset sequences for lbdr_pkt_router.
// -----------------------------------------------------------------------------
module tb_lbdr_pkt_router;

   localparam logic [2:0] HDR  = 3'b001;
   localparam logic [2:0] TAIL = 3'b100;
   localparam logic [2:0] PAY  = 3'b010;
   localparam logic [2:0] OTH  = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic        empty;
   logic [2:0]  flit_id;
   logic [3:0]  dst_addr;
   logic        rd;
   logic        cfg_we;
   logic [7:0]  cfg_rxy;
   logic [3:0]  cfg_cx;
   logic [3:0]  cfg_cur;
   logic        Nport, Eport, Wport, Sport, Lport;
   logic        busy, route_err, proto_err, cfg_err;
   logic [15:0] pkt_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lbdr_pkt_router dut (
      .clk(clk), .rst(rst), .empty(empty), .flit_id(flit_id),
      .dst_addr(dst_addr), .rd(rd), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy),
      .cfg_cx(cfg_cx), .cfg_cur(cfg_cur),
      .Nport(Nport), .Eport(Eport), .Wport(Wport), .Sport(Sport), .Lport(Lport),
      .busy(busy), .route_err(route_err), .proto_err(proto_err),
      .cfg_err(cfg_err), .pkt_cnt(pkt_cnt)
   );

   typedef struct {
      logic        empty;
      logic [2:0]  fid;
      logic [3:0]  dst;
      logic        rd;
      logic        we;
      logic [3:0]  cx;
      logic [4:0]  e_ports;   // {L,S,W,E,N}
      logic        e_busy;
      logic        e_rerr;
      logic        e_perr;
      logic        e_cerr;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic e, input logic [2:0] f, input logic [3:0] d,
                              input logic r, input logic w, input logic [3:0] c,
                              input logic [4:0] p, input logic b, input logic re,
                              input logic pe, input logic ce, input logic [15:0] n);
      vec_t t;
      t.empty = e; t.fid = f; t.dst = d; t.rd = r; t.we = w; t.cx = c;
      t.e_ports = p; t.e_busy = b; t.e_rerr = re; t.e_perr = pe; t.e_cerr = ce; t.e_cnt = n;
      return t;
   endfunction

   task automatic check(input string name, input logic [4:0] ep, input logic eb,
                        input logic er, input logic epe, input logic ece,
                        input logic [15:0] ec);
      logic [4:0] ap;
      ap = {Lport, Sport, Wport, Eport, Nport};
      checks++;
      if (ap !== ep || busy !== eb || route_err !== er || proto_err !== epe ||
          cfg_err !== ece || pkt_cnt !== ec) begin
         errors++;
         $display("FAIL %s: got ports=%b busy=%b rerr=%b perr=%b cerr=%b cnt=%0d, want ports=%b busy=%b rerr=%b perr=%b cerr=%b cnt=%0d",
                  name, ap, busy, route_err, proto_err, cfg_err, pkt_cnt,
                  ep, eb, er, epe, ece, ec);
      end else begin
         $display("ok   %s: ports=%b busy=%b rerr=%b perr=%b cerr=%b cnt=%0d",
                  name, ap, busy, route_err, proto_err, cfg_err, pkt_cnt);
      end
   endtask

   task automatic drive(input logic e, input logic [2:0] f, input logic [3:0] d,
                        input logic r, input logic w, input logic [7:0] rx,
                        input logic [3:0] c, input logic [3:0] cu);
      empty = e; flit_id = f; dst_addr = d; rd = r;
      cfg_we = w; cfg_rxy = rx; cfg_cx = c; cfg_cur = cu;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference: route chosen from signed coordinate deltas.
   function automatic logic [4:0] model_route(input logic [3:0] cur, input logic [3:0] dst,
                                              input logic [7:0] rxy, input logic [3:0] cx);
      int dx, dy;
      dy = int'(dst[3:2]) - int'(cur[3:2]);
      dx = int'(dst[1:0]) - int'(cur[1:0]);
      if (dx == 0 && dy == 0) return 5'b10000;
      if (dy < 0 && cx[0] && (dx == 0 || (dx > 0 ? rxy[0] : rxy[1]))) return 5'b00001;
      if (dx > 0 && cx[1] && (dy == 0 || (dy < 0 ? rxy[2] : rxy[3]))) return 5'b00010;
      if (dx < 0 && cx[2] && (dy == 0 || (dy < 0 ? rxy[4] : rxy[5]))) return 5'b00100;
      if (dy > 0 && cx[3] && (dx == 0 || (dx > 0 ? rxy[6] : rxy[7]))) return 5'b01000;
      return 5'b00000;
   endfunction

   initial begin
      logic        m_lock;
      logic [4:0]  m_ports;
      logic [15:0] m_cnt;
      logic [7:0]  m_rxy;
      logic [3:0]  m_cx, m_cur;
      logic        m_rerr, m_perr, m_cerr;
      logic [4:0]  r;

      drive(1'b1, PAY, 4'h0, 1'b0, 1'b0, 8'h3C, 4'hF, 4'h5);
      rst = 1'b0;
      #2;
      check("reset_state", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;

      tbl.push_back(v(1, PAY, 4'h0, 0, 0, 4'hF, 5'b00000, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, HDR, 4'h7, 1, 0, 4'hF, 5'b00010, 1, 0, 0, 0, 1));  // east
      tbl.push_back(v(0, PAY, 4'h0, 1, 0, 4'hF, 5'b00010, 1, 0, 0, 0, 1));  // payload ignores dst
      tbl.push_back(v(0, TAIL, 4'h0, 1, 0, 4'hF, 5'b00000, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, HDR, 4'h0, 1, 0, 4'hF, 5'b00100, 1, 0, 0, 0, 2));  // NW -> west
      tbl.push_back(v(0, TAIL, 4'h0, 1, 0, 4'hF, 5'b00000, 0, 0, 0, 0, 2));
      tbl.push_back(v(0, HDR, 4'h5, 1, 0, 4'hF, 5'b10000, 1, 0, 0, 0, 3));  // local
      tbl.push_back(v(0, PAY, 4'h0, 1, 0, 4'hF, 5'b10000, 1, 0, 0, 0, 3));
      tbl.push_back(v(1, PAY, 4'h0, 1, 0, 4'hF, 5'b10000, 1, 0, 0, 0, 3));  // empty holds
      tbl.push_back(v(0, TAIL, 4'h0, 0, 0, 4'hF, 5'b10000, 1, 0, 0, 0, 3)); // tail not consumed
      tbl.push_back(v(0, TAIL, 4'h0, 1, 0, 4'hF, 5'b00000, 0, 0, 0, 0, 3));
      tbl.push_back(v(1, PAY, 4'h0, 0, 1, 4'hD, 5'b00000, 0, 0, 0, 0, 3));  // Ce=0
      tbl.push_back(v(0, HDR, 4'h7, 1, 0, 4'hD, 5'b00000, 0, 1, 0, 0, 3));  // route_err
      tbl.push_back(v(1, PAY, 4'h0, 0, 0, 4'hD, 5'b00000, 0, 0, 0, 0, 3));
      tbl.push_back(v(1, PAY, 4'h0, 0, 1, 4'hF, 5'b00000, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, HDR, 4'h7, 1, 0, 4'hF, 5'b00010, 1, 0, 0, 0, 4));
      tbl.push_back(v(0, HDR, 4'h0, 1, 0, 4'hF, 5'b00010, 1, 0, 1, 0, 4));  // header in LOCK
      tbl.push_back(v(1, PAY, 4'h0, 0, 1, 4'h0, 5'b00010, 1, 0, 0, 1, 4));  // cfg in LOCK
      tbl.push_back(v(0, TAIL, 4'h0, 1, 0, 4'hF, 5'b00000, 0, 0, 0, 0, 4));
      tbl.push_back(v(0, HDR, 4'h7, 1, 0, 4'hF, 5'b00010, 1, 0, 0, 0, 5));  // back-to-back, cfg unchanged
      tbl.push_back(v(0, TAIL, 4'h0, 1, 0, 4'hF, 5'b00000, 0, 0, 0, 0, 5));
      tbl.push_back(v(0, PAY, 4'h0, 1, 0, 4'hF, 5'b00000, 0, 0, 1, 0, 5));  // non-header idle
      tbl.push_back(v(0, HDR, 4'h7, 1, 1, 4'hD, 5'b00010, 1, 0, 0, 0, 6));  // old cfg used
      tbl.push_back(v(0, TAIL, 4'h0, 1, 0, 4'hD, 5'b00000, 0, 0, 0, 0, 6));
      tbl.push_back(v(0, HDR, 4'h7, 1, 0, 4'hD, 5'b00000, 0, 1, 0, 0, 6));  // new cfg in effect
      tbl.push_back(v(1, PAY, 4'h0, 0, 1, 4'hF, 5'b00000, 0, 0, 0, 0, 6));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].empty, tbl[i].fid, tbl[i].dst, tbl[i].rd, tbl[i].we,
               8'h3C, tbl[i].cx, 4'h5);
         tick();
         check($sformatf("vec%0d", i), tbl[i].e_ports, tbl[i].e_busy,
               tbl[i].e_rerr, tbl[i].e_perr, tbl[i].e_cerr, tbl[i].e_cnt);
      end

      // Randomized run against the behavioural model.
      m_lock = 1'b0; m_ports = 5'b0; m_cnt = 16'd6;
      m_rxy = 8'h3C; m_cx = 4'hF; m_cur = 4'h5;
      for (int i = 0; i < 400; i++) begin
         logic       e, rdv, we;
         logic [2:0] f;
         logic [3:0] d, c, cu;
         logic [7:0] rx;
         e  = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0: f = HDR;
            1: f = TAIL;
            2: f = PAY;
            default: f = OTH;
         endcase
         d   = 4'($urandom);
         rdv = 1'($urandom);
         we  = ($urandom_range(0, 9) == 0);
         rx  = 8'($urandom);
         c   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         cu  = 4'($urandom);

         m_rerr = 1'b0; m_perr = 1'b0; m_cerr = 1'b0;
         if (!m_lock) begin
            if (!e) begin
               if (f == HDR) begin
                  r = model_route(m_cur, d, m_rxy, m_cx);
                  if (r != 5'b0) begin
                     m_ports = r; m_lock = 1'b1; m_cnt = m_cnt + 16'd1;
                  end else begin
                     m_rerr = 1'b1;
                  end
               end else begin
                  m_perr = 1'b1;
               end
            end
            if (we) begin
               m_rxy = rx; m_cx = c; m_cur = cu;
            end
         end else begin
            m_cerr = we;
            if (!e && f == TAIL && rdv) begin
               m_ports = 5'b0; m_lock = 1'b0;
            end else if (!e && f == HDR) begin
               m_perr = 1'b1;
            end
         end

         drive(e, f, d, rdv, we, rx, c, cu);
         tick();
         check($sformatf("rnd%0d", i), m_ports, m_lock, m_rerr, m_perr, m_cerr, m_cnt);
      end

      // Asynchronous reset mid-packet, configuration restored to defaults.
      drive(1'b1, PAY, 4'h0, 1'b0, 1'b0, 8'h3C, 4'hF, 4'h5);
      rst = 1'b0;
      #1;
      check("rst_pulse", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      tick();
      #2 rst = 1'b1;
      drive(1'b1, PAY, 4'h0, 1'b0, 1'b1, 8'h3C, 4'hF, 4'hF);      // own address (3,3)
      tick();
      check("cfg_cur_ff", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      drive(0, HDR, 4'h5, 1'b1, 1'b0, 8'h3C, 4'hF, 4'h5);          // NW from (3,3) -> west
      tick();
      check("pre_rst_hdr", 5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
      drive(0, PAY, 4'h0, 1'b1, 1'b0, 8'h3C, 4'hF, 4'h5);
      tick();
      check("pre_rst_pay", 5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
      #3 rst = 1'b0;
      #1;
      check("rst_midpkt", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      tick();
      check("rst_held", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      #3 rst = 1'b1;
      drive(0, HDR, 4'h7, 1'b1, 1'b0, 8'h3C, 4'hF, 4'h5);          // default cur -> east
      tick();
      check("post_rst_hdr", 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
      drive(0, TAIL, 4'h0, 1'b1, 1'b0, 8'h3C, 4'hF, 4'h5);
      tick();
      check("post_rst_tail", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
